// File: rtl/mix_pkg.sv
// Shared types and constants for the voice mixer.
// Sample width, accumulator sizing, FSM states and clip limits.
package mix_pkg;

  localparam int SAMPLE_W = 18;
  localparam int SAT_MAX  = (1 << (SAMPLE_W - 1)) - 1;
  localparam int SAT_MIN  = -(1 << (SAMPLE_W - 1));

  function automatic int acc_w(input int dw, input int n);
    return dw + $clog2(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WAIT_RDY,
    WAIT_REL,
    SCALE,
    OUT
  } state_t;

endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturator.
// Narrows IN_W to OUT_W, clamping to the OUT_W two's complement range.
module sat_clip #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 18
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam logic [IN_W-1:0] MAXV =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MINV =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    if ($signed(din) > $signed(MAXV)) begin
      dout = MAXV[OUT_W-1:0];
    end else if ($signed(din) < $signed(MINV)) begin
      dout = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Pulls one sample per enabled voice per audio tick via ready/received,
// sums, applies master volume, saturates and presents the mix.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 18,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_tick,
  input  logic [NUM_VOICES-1:0]        voice_enable,
  input  logic [NUM_VOICES-1:0]        voice_ready,
  input  logic [NUM_VOICES*DATA_W-1:0] voice_data,
  output logic [NUM_VOICES-1:0]        voice_received,
  input  logic [7:0]                   master_vol,
  output logic [DATA_W-1:0]            mix_out,
  output logic                         mix_valid,
  output logic                         overrun,
  output logic [NUM_VOICES-1:0]        voice_timeout
);

  import mix_pkg::*;

  localparam int ACC_W  = acc_w(DATA_W, NUM_VOICES);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TC_W   = $clog2(TIMEOUT + 1);
  localparam int PROD_W = ACC_W + 9;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [TC_W-1:0]           tcnt;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         sat_q;

  logic signed [DATA_W-1:0]  sample;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  scaled;
  logic [DATA_W-1:0]         clipped;
  logic                      last;
  logic                      tc_hit;

  assign sample     = $signed(voice_data[idx*DATA_W +: DATA_W]);
  assign sample_ext = ACC_W'(sample);
  assign prod       = PROD_W'(acc) *
                      PROD_W'($signed({1'b0, master_vol}));
  assign scaled     = prod >>> 7;
  assign last       = (idx == IDX_W'(NUM_VOICES - 1));
  assign tc_hit     = (tcnt == TC_W'(TIMEOUT));

  sat_clip #(
    .IN_W  (PROD_W),
    .OUT_W (DATA_W)
  ) u_clip (
    .din  (scaled),
    .dout (clipped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      tcnt           <= '0;
      acc            <= '0;
      sat_q          <= '0;
      voice_received <= '0;
      mix_out        <= '0;
      mix_valid      <= 1'b0;
      overrun        <= 1'b0;
      voice_timeout  <= '0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (sample_tick) begin
            acc           <= '0;
            idx           <= '0;
            voice_timeout <= '0;
            state         <= SEL;
          end
        end
        SEL: begin
          if (!voice_enable[idx]) begin
            if (last) state <= SCALE;
            else      idx   <= idx + 1'b1;
          end else begin
            tcnt  <= '0;
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (voice_ready[idx]) begin
            acc                 <= acc + sample_ext;
            voice_received[idx] <= 1'b1;
            tcnt                <= '0;
            state               <= WAIT_REL;
          end else if (tc_hit) begin
            voice_timeout[idx] <= 1'b1;
            if (last) begin
              state <= SCALE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SEL;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!voice_ready[idx] || tc_hit) begin
            voice_received <= '0;
            if (voice_ready[idx]) voice_timeout[idx] <= 1'b1;
            if (last) begin
              state <= SCALE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SEL;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SCALE: begin
          sat_q <= clipped;
          state <= OUT;
        end
        OUT: begin
          mix_out   <= sat_q;
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: responsive voice generators plus a
// plain-arithmetic reference for the mixed, scaled, clipped sample.
module tb_voice_mixer;

  localparam int N  = 4;
  localparam int DW = 18;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 sample_tick = 1'b0;
  logic [N-1:0]         voice_enable = '1;
  wire  [N-1:0]         voice_ready;
  wire  [N*DW-1:0]      voice_data;
  logic [N-1:0]         voice_received;
  logic [7:0]           master_vol = 8'd128;
  logic signed [DW-1:0] mix_out;
  logic                 mix_valid;
  logic                 overrun;
  logic [N-1:0]         voice_timeout;

  int gen_data [N];
  bit silent   [N];
  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  voice_mixer #(
    .NUM_VOICES (N),
    .DATA_W     (DW),
    .TIMEOUT    (255)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .voice_enable   (voice_enable),
    .voice_ready    (voice_ready),
    .voice_data     (voice_data),
    .voice_received (voice_received),
    .master_vol     (master_vol),
    .mix_out        (mix_out),
    .mix_valid      (mix_valid),
    .overrun        (overrun),
    .voice_timeout  (voice_timeout)
  );

  // One generator per voice: offer, wait for ack, drop, wait for ack release
  for (genvar g = 0; g < N; g++) begin : gen_v
    logic          r   = 1'b0;
    logic [DW-1:0] d   = '0;
    int            st  = 0;
    int            dly = 0;
    always @(negedge clk) begin
      case (st)
        0: begin
          r = 1'b0;
          if (!silent[g]) begin
            if (dly == 0) begin
              d  = gen_data[g][DW-1:0];
              r  = 1'b1;
              st = 1;
            end else begin
              dly--;
            end
          end
        end
        1: begin
          if (voice_received[g]) begin
            r  = 1'b0;
            st = 2;
          end else if (silent[g]) begin
            r  = 1'b0;
            st = 0;
          end else begin
            d = gen_data[g][DW-1:0];
          end
        end
        default: begin
          if (!voice_received[g]) begin
            dly = $urandom_range(0, 3);
            st  = 0;
          end
        end
      endcase
    end
    assign voice_ready[g]           = r;
    assign voice_data[g*DW +: DW]   = d;
  end

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model();
    longint s = 0;
    longint p;
    longint q;
    int     v;
    for (int i = 0; i < N; i++)
      if (voice_enable[i] && !silent[i]) s += gen_data[i];
    v = master_vol;
    p = s * v;
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q--;
    if (q > 131071) q = 131071;
    if (q < -131072) q = -131072;
    return q;
  endfunction

  function automatic logic [N-1:0] model_to();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = voice_enable[i] & silent[i];
    return t;
  endfunction

  task automatic run_frame(input int tick2, input string tag);
    longint       e;
    logic [N-1:0] eto;
    logic [N-1:0] seen;
    int           nv;
    int           nov;
    int           post;
    bit           multi;
    e     = model();
    eto   = model_to();
    seen  = '0;
    nv    = 0;
    nov   = 0;
    post  = 0;
    multi = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int c = 1; c <= 3000 && post < 4; c++) begin
      @(negedge clk);
      sample_tick = (c == tick2);
      if (mix_valid) nv++;
      if (overrun) nov++;
      seen |= voice_received;
      if ($countones(voice_received) > 1) multi = 1'b1;
      if (nv > 0) post++;
    end
    sample_tick = 1'b0;
    chk({tag, "_mix"},   longint'(mix_out), e);
    chk({tag, "_valid"}, nv, 1);
    chk({tag, "_ovr"},   nov, (tick2 > 0) ? 1 : 0);
    chk({tag, "_to"},    voice_timeout, eto);
    chk({tag, "_dis"},   seen & ~voice_enable, 0);
    chk({tag, "_one"},   multi, 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < N; i++) begin
      gen_data[i] = 0;
      silent[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_mix",   longint'(mix_out), 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_rcv",   voice_received, 0);
    chk("rst_to",    voice_timeout, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    gen_data = '{1000, 2000, -500, 0};
    run_frame(0, "t1");
    chk("t1_lit", longint'(mix_out), 2500);

    gen_data   = '{131071, 131071, 131071, 131071};
    master_vol = 8'd255;
    run_frame(0, "t2p");
    chk("t2p_lit", longint'(mix_out), 131071);
    gen_data = '{-131072, -131072, -131072, -131072};
    run_frame(0, "t2n");
    chk("t2n_lit", longint'(mix_out), -131072);

    master_vol   = 8'd128;
    gen_data     = '{3000, 5, 777, -1200};
    voice_enable = 4'b1011;
    silent[1]    = 1'b1;
    run_frame(0, "t3");
    chk("t3_lit", longint'(mix_out), 1800);
    chk("t3_to_lit", voice_timeout, 4'b0010);
    silent[1]    = 1'b0;
    voice_enable = 4'b1111;

    gen_data = '{10, 20, 30, 40};
    run_frame(5, "t4");

    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    w = 0;
    while (!voice_received[0] && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("t5_seen_rcv", voice_received[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rcv",   voice_received, 0);
    chk("t5_mix",   longint'(mix_out), 0);
    chk("t5_valid", mix_valid, 0);
    chk("t5_to",    voice_timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    gen_data = '{-7, 300, 4000, -50000};
    run_frame(0, "t5b");

    master_vol = 8'd0;
    run_frame(0, "t6z");
    chk("t6z_lit", longint'(mix_out), 0);
    master_vol   = 8'd64;
    voice_enable = 4'b0001;
    gen_data     = '{1001, 9, 9, 9};
    run_frame(0, "t6p");
    chk("t6p_lit", longint'(mix_out), 500);
    gen_data = '{-1001, 9, 9, 9};
    run_frame(0, "t6n");
    chk("t6n_lit", longint'(mix_out), -501);

    voice_enable = 4'b0000;
    run_frame(0, "t7");

    for (int k = 0; k < 8; k++) begin
      voice_enable = 4'($urandom);
      master_vol   = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        w           = $urandom_range(0, 262143);
        gen_data[i] = (w > 131071) ? w - 262144 : w;
        silent[i]   = ($urandom_range(0, 7) == 0);
      end
      run_frame(0, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
